spi_ram_responder: RTL and testbench

SPI_RAM_RESPONDER -- requirements
Module: spi_ram_responder

---
 rtl/spi_ram_responder.sv | 311 +++++++++++++++++++++++++++++++
 tb/tb_spi_ram_responder.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_ram_responder.sv
// spi_ram_responder: SPI mode-0 slave backed by a 2^ADDR_BITS byte RAM.
// Commands: 0x03 read, 0x02 write, anything else ignored until CS_N rises.
// Optional feature macro SPI_RESP_FAST_READ_EN adds command 0x0B
// (24 address bits, 8 dummy bits, then read data).
// SCK, CS_N and MOSI are oversampled on clk, so clk must run at least 8x SCK.
module spi_ram_responder #(
    parameter int ADDR_BITS   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic resetn,
    input  logic CLK,
    input  logic CS_N,
    input  logic MOSI,
    output logic MISO,
    output logic active,
    output logic wr_pulse
);

    localparam int DEPTH = 1 << ADDR_BITS;
    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam logic [7:0] CMD_WRITE = 8'h02;
`ifdef SPI_RESP_FAST_READ_EN
    localparam logic [7:0] CMD_FAST_READ = 8'h0B;
`endif

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CMD    = 3'd1,
        ST_ADDR   = 3'd2,
        ST_DUMMY  = 3'd3,
        ST_READ   = 3'd4,
        ST_WRITE  = 3'd5,
        ST_IGNORE = 3'd6
    } state_t;

    // Commands that carry an address phase.
    function automatic logic is_addr_cmd(input logic [7:0] cmd);
        logic hit;
        hit = (cmd == CMD_READ) || (cmd == CMD_WRITE);
`ifdef SPI_RESP_FAST_READ_EN
        hit = hit || (cmd == CMD_FAST_READ);
`endif
        return hit;
    endfunction

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   sck_prev_q, sck_prev_d;
    logic                   cs_prev_q, cs_prev_d;
    logic [4:0]             bit_cnt_q, bit_cnt_d;
    logic [7:0]             shift_q, shift_d;
    logic [7:0]             cmd_q, cmd_d;
    logic [7:0]             tx_q, tx_d;
    logic [ADDR_BITS-1:0]   addr_q, addr_d;
    logic                   miso_q, miso_d;
    logic                   active_q, active_d;
    logic                   wr_pulse_q, wr_pulse_d;

    logic [7:0]             mem [DEPTH];

    logic                   sck_s, cs_s, mosi_s;
    logic                   sck_rise_s, sck_fall_s, cs_rise_s, cs_fall_s;
    logic [7:0]             rx_byte_s;
    logic [ADDR_BITS-1:0]   addr_shift_s, addr_inc_s, rd_addr_s;
    logic [7:0]             rd_data_s;
    logic                   mem_we_s;

    // Synchronizer chains and one extra sample each for edge detection.
    always_comb begin
        sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], CLK};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], CS_N};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
        sck_s       = sck_sync_q[SYNC_STAGES-1];
        cs_s        = cs_sync_q[SYNC_STAGES-1];
        mosi_s      = mosi_sync_q[SYNC_STAGES-1];
        sck_prev_d  = sck_s;
        cs_prev_d   = cs_s;
        sck_rise_s  = sck_s & ~sck_prev_q;
        sck_fall_s  = ~sck_s & sck_prev_q;
        cs_rise_s   = cs_s & ~cs_prev_q;
        cs_fall_s   = ~cs_s & cs_prev_q;
        rx_byte_s   = {shift_q[6:0], mosi_s};
        addr_shift_s = {addr_q[ADDR_BITS-2:0], mosi_s};
        addr_inc_s  = addr_q + {{(ADDR_BITS-1){1'b0}}, 1'b1};
    end

    // Memory read address: the address being completed, the held
    // address after dummy bits, or the next address while streaming.
    always_comb begin
        case (state_q)
            ST_ADDR:  rd_addr_s = addr_shift_s;
            ST_DUMMY: rd_addr_s = addr_q;
            ST_READ:  rd_addr_s = addr_inc_s;
            default:  rd_addr_s = addr_q;
        endcase
        rd_data_s = mem[rd_addr_s];
    end

    // State register plus all datapath and output flops.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            sck_sync_q  <= '0;
            cs_sync_q   <= '0;
            mosi_sync_q <= '0;
            sck_prev_q  <= 1'b0;
            cs_prev_q   <= 1'b0;
            bit_cnt_q   <= 5'd0;
            shift_q     <= 8'h00;
            cmd_q       <= 8'h00;
            tx_q        <= 8'h00;
            addr_q      <= '0;
            miso_q      <= 1'b0;
            active_q    <= 1'b0;
            wr_pulse_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            sck_sync_q  <= sck_sync_d;
            cs_sync_q   <= cs_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sck_prev_q  <= sck_prev_d;
            cs_prev_q   <= cs_prev_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            cmd_q       <= cmd_d;
            tx_q        <= tx_d;
            addr_q      <= addr_d;
            miso_q      <= miso_d;
            active_q    <= active_d;
            wr_pulse_q  <= wr_pulse_d;
        end
    end

    // Byte storage; deliberately not reset so contents survive resetn.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem[addr_q] <= rx_byte_s;
        end
    end

    // Next-state logic; CS_N rise wins over any coincident SCK edge.
    always_comb begin
        state_d = state_q;
        if (cs_rise_s) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cs_fall_s) begin
                        state_d = ST_CMD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_CMD: begin
                    if (sck_rise_s && (bit_cnt_q == 5'd7)) begin
                        state_d = is_addr_cmd(rx_byte_s) ? ST_ADDR : ST_IGNORE;
                    end else begin
                        state_d = ST_CMD;
                    end
                end
                ST_ADDR: begin
                    if (sck_rise_s && (bit_cnt_q == 5'd23)) begin
                        case (cmd_q)
                            CMD_READ:      state_d = ST_READ;
                            CMD_WRITE:     state_d = ST_WRITE;
`ifdef SPI_RESP_FAST_READ_EN
                            CMD_FAST_READ: state_d = ST_DUMMY;
`endif
                            default:       state_d = ST_IGNORE;
                        endcase
                    end else begin
                        state_d = ST_ADDR;
                    end
                end
`ifdef SPI_RESP_FAST_READ_EN
                ST_DUMMY: begin
                    if (sck_rise_s && (bit_cnt_q == 5'd7)) begin
                        state_d = ST_READ;
                    end else begin
                        state_d = ST_DUMMY;
                    end
                end
`endif
                ST_READ:   state_d = ST_READ;
                ST_WRITE:  state_d = ST_WRITE;
                ST_IGNORE: state_d = ST_IGNORE;
                default:   state_d = ST_IGNORE;
            endcase
        end
    end

    // Datapath and output logic: shifting, counting, memory access, MISO.
    always_comb begin
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        cmd_d      = cmd_q;
        tx_d       = tx_q;
        addr_d     = addr_q;
        miso_d     = 1'b0;
        wr_pulse_d = 1'b0;
        mem_we_s   = 1'b0;
        // active follows the transaction, so a reset with CS_N held low
        // keeps it clear until a fresh CS_N fall starts a new one.
        active_d   = (state_d != ST_IDLE);
        if (cs_rise_s) begin
            bit_cnt_d = 5'd0;
            shift_d   = 8'h00;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cs_fall_s) begin
                        bit_cnt_d = 5'd0;
                        shift_d   = 8'h00;
                        addr_d    = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q;
                    end
                end
                ST_CMD: begin
                    if (sck_rise_s) begin
                        shift_d = rx_byte_s;
                        if (bit_cnt_q == 5'd7) begin
                            cmd_d     = rx_byte_s;
                            bit_cnt_d = 5'd0;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 5'd1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q;
                    end
                end
                ST_ADDR: begin
                    if (sck_rise_s) begin
                        addr_d = addr_shift_s;
                        if (bit_cnt_q == 5'd23) begin
                            bit_cnt_d = 5'd0;
                            tx_d      = rd_data_s;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 5'd1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q;
                    end
                end
`ifdef SPI_RESP_FAST_READ_EN
                ST_DUMMY: begin
                    if (sck_rise_s) begin
                        if (bit_cnt_q == 5'd7) begin
                            bit_cnt_d = 5'd0;
                            tx_d      = rd_data_s;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 5'd1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q;
                    end
                end
`endif
                ST_READ: begin
                    miso_d = miso_q;
                    if (sck_fall_s) begin
                        miso_d = tx_q[7];
                        if (bit_cnt_q == 5'd7) begin
                            // Last bit of this byte goes out; next byte
                            // is preloaded so streaming has no gap.
                            tx_d      = rd_data_s;
                            addr_d    = addr_inc_s;
                            bit_cnt_d = 5'd0;
                        end else begin
                            tx_d      = {tx_q[6:0], 1'b0};
                            bit_cnt_d = bit_cnt_q + 5'd1;
                        end
                    end else begin
                        tx_d = tx_q;
                    end
                end
                ST_WRITE: begin
                    if (sck_rise_s) begin
                        shift_d = rx_byte_s;
                        if (bit_cnt_q == 5'd7) begin
                            mem_we_s   = 1'b1;
                            wr_pulse_d = 1'b1;
                            addr_d     = addr_inc_s;
                            bit_cnt_d  = 5'd0;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 5'd1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q;
                    end
                end
                ST_IGNORE: begin
                    miso_d = 1'b0;
                end
                default: begin
                    bit_cnt_d = 5'd0;
                    shift_d   = 8'h00;
                end
            endcase
        end
    end

    assign MISO     = miso_q;
    assign active   = active_q;
    assign wr_pulse = wr_pulse_q;

endmodule

// File: tb/tb_spi_ram_responder.sv
// Self-checking bench for spi_ram_responder: drives SPI mode-0 frames,
// keeps a byte model of the RAM, and compares read data via a scoreboard.
module tb_spi_ram_responder;

    localparam int HALF = 80;  // SCK half period in ns (clk period 10 ns)

    logic clk = 1'b0;
    logic resetn;
    logic sck;
    logic cs_n;
    logic mosi;
    logic miso;
    logic active;
    logic wr_pulse;

    int n_checks = 0;
    int n_errors = 0;
    int wr_count = 0;
    int base;
    logic [7:0] exp_q[$];
    logic [7:0] rx;

    spi_ram_responder #(.ADDR_BITS(8), .SYNC_STAGES(2)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .CLK      (sck),
        .CS_N     (cs_n),
        .MOSI     (mosi),
        .MISO     (miso),
        .active   (active),
        .wr_pulse (wr_pulse)
    );

    always #5 clk = ~clk;

    // Count committed bytes, sampled away from the active edge.
    always @(negedge clk) begin
        if (resetn && wr_pulse) begin
            wr_count <= wr_count + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Shift n bits of tx (MSB first) and capture MISO before each rise.
    task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rxv);
        rxv = 8'h00;
        for (int i = 7; i >= 8 - n; i--) begin
            mosi = tx[i];
            #(HALF);
            rxv = {rxv[6:0], miso};
            sck = 1'b1;
            #(HALF);
            sck = 1'b0;
        end
    endtask

    task automatic cs_low();
        cs_n = 1'b0;
        #(HALF);
    endtask

    task automatic cs_high();
        #(HALF);
        cs_n = 1'b1;
        #(2 * HALF);
    endtask

    task automatic send_hdr(input logic [7:0] cmd, input logic [23:0] addr);
        logic [7:0] d;
        spi_bits(cmd, 8, d);
        spi_bits(addr[23:16], 8, d);
        spi_bits(addr[15:8], 8, d);
        spi_bits(addr[7:0], 8, d);
    endtask

    // Clock n bytes out and compare each against the scoreboard head.
    task automatic read_bytes(input int n, input string tag);
        logic [7:0] d;
        for (int k = 0; k < n; k++) begin
            spi_bits(8'h00, 8, d);
            if (exp_q.size() == 0) begin
                chk({tag, "_sb_empty"}, 32'd1, 32'd0);
            end else begin
                chk(tag, {24'h0, d}, {24'h0, exp_q.pop_front()});
            end
        end
    endtask

    // Write n bytes of data (MSB byte first) starting at addr.
    task automatic spi_write(input logic [23:0] addr, input logic [31:0] data, input int n);
        logic [7:0] d;
        cs_low();
        send_hdr(8'h02, addr);
        chk("active_txn", {31'h0, active}, 32'd1);
        for (int k = 0; k < n; k++) begin
            spi_bits(data[31 - 8 * k -: 8], 8, d);
        end
        cs_high();
    endtask

    task automatic spi_read(input logic [7:0] cmd, input logic [23:0] addr, input int n,
                            input logic dummy, input string tag);
        logic [7:0] d;
        cs_low();
        send_hdr(cmd, addr);
        if (dummy) begin
            spi_bits(8'h00, 8, d);
        end
        read_bytes(n, tag);
        cs_high();
        chk({tag, "_miso_idle"}, {31'h0, miso}, 32'd0);
    endtask

    // Global time limit so the run always ends.
    initial begin
        #(3_000_000);
        $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1, "time limit");
    end

    initial begin
        resetn = 1'b0;
        sck    = 1'b0;
        cs_n   = 1'b1;
        mosi   = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_miso", {31'h0, miso}, 32'd0);
        chk("rst_active", {31'h0, active}, 32'd0);
        chk("rst_wr_pulse", {31'h0, wr_pulse}, 32'd0);
        resetn = 1'b1;
        repeat (10) @(negedge clk);
        chk("idle_active", {31'h0, active}, 32'd0);

        // Write-read round trip.
        base = wr_count;
        spi_write(24'h000010, 32'hA53C0000, 2);
        chk("wr_cnt_basic", wr_count - base, 32'd2);
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h3C);
        spi_read(8'h03, 24'h000010, 2, 1'b0, "rd_basic");

        // Address wrap at the top of memory; upper address bits dropped.
        base = wr_count;
        spi_write(24'h1234FF, 32'h11220000, 2);
        chk("wr_cnt_wrap", wr_count - base, 32'd2);
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        spi_read(8'h03, 24'h0000FF, 2, 1'b0, "rd_wrap");
        exp_q.push_back(8'h22);
        spi_read(8'h03, 24'h000000, 1, 1'b0, "rd_zero");

        // Abort mid-byte: no commit, old content kept.
        spi_write(24'h000020, 32'h5A000000, 1);
        base = wr_count;
        cs_low();
        send_hdr(8'h02, 24'h000020);
        spi_bits(8'hFF, 5, rx);
        cs_high();
        chk("wr_cnt_abort", wr_count - base, 32'd0);
        chk("abort_miso", {31'h0, miso}, 32'd0);
        chk("abort_active", {31'h0, active}, 32'd0);
        exp_q.push_back(8'h5A);
        spi_read(8'h03, 24'h000020, 1, 1'b0, "rd_abort");

        // Unknown command: MISO stays low, nothing written.
        base = wr_count;
        cs_low();
        spi_bits(8'h9F, 8, rx);
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back(8'h00);
        end
        read_bytes(4, "rd_unknown");
        cs_high();
        chk("wr_cnt_unknown", wr_count - base, 32'd0);

        // Fast read (0x0B) with dummy byte.
`ifdef SPI_RESP_FAST_READ_EN
        exp_q.push_back(8'hA5);
`else
        exp_q.push_back(8'h00);
`endif
        spi_read(8'h0B, 24'h000010, 1, 1'b1, "rd_fast");

        // Reset while a read byte is on the wire.
        cs_low();
        send_hdr(8'h03, 24'h000010);
        #(HALF);
        chk("pre_rst_miso", {31'h0, miso}, 32'd1);
        resetn = 1'b0;
        #1;
        chk("mid_rst_miso", {31'h0, miso}, 32'd0);
        chk("mid_rst_active", {31'h0, active}, 32'd0);
        #9;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        repeat (6) @(negedge clk);
        chk("post_rst_active", {31'h0, active}, 32'd0);
        cs_high();
        exp_q.push_back(8'hA5);
        spi_read(8'h03, 24'h000010, 1, 1'b0, "rd_after_rst");

        chk("sb_drained", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
